// File: rtl/fetch_pc_unit_if.sv
// Fetch-side bus: PC-select/hazard controls in, instruction memory address/data.
// The master modport is the fetch unit; the slave modport is the memory/control side.
interface fetch_pc_unit_if;
    logic [1:0]  sel_pc;
    logic        flush;
    logic        stall;
    logic [31:0] jr_addr;
    logic [31:0] exe_pc4;
    logic [31:0] exe_imm;
    logic [31:0] inst_addr;
    logic [31:0] inst_rdata;

    modport master (
        input  sel_pc, flush, stall, jr_addr, exe_pc4, exe_imm, inst_rdata,
        output inst_addr
    );

    modport slave (
        output sel_pc, flush, stall, jr_addr, exe_pc4, exe_imm, inst_rdata,
        input  inst_addr
    );
endinterface

// File: rtl/fetch_pc_unit.sv
// IF-stage controller: PC register, next-PC mux, IF/ID register, BOOT/RUN/HALT FSM
// and saturating fetch/bubble counters.
module fetch_pc_unit #(
    parameter logic [31:0] PC_RESET  = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD  = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             nrst,
    fetch_pc_unit_if.master  bus,
    output logic [31:0]      if_id_inst,
    output logic [31:0]      if_id_pc4,
    output logic             if_id_valid,
    output logic             halted,
    output logic [CNT_W-1:0] fetch_cnt,
    output logic [CNT_W-1:0] bubble_cnt
);

    typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_HALT} state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt, pc4;
    logic [31:0] jump_tgt, br_tgt;
    logic        redirect, halt_det, load_bubble, load_accept;

    assign pc4           = pc + 32'd4;
    assign jump_tgt      = {if_id_pc4[31:28], if_id_inst[25:0], 2'b00};
    assign br_tgt        = bus.exe_pc4 + (bus.exe_imm << 2);
    assign redirect      = (bus.sel_pc != 2'd0);
    assign bus.inst_addr = pc;
    assign halted        = (state == ST_HALT);

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latches).
        state_nxt   = state;
        pc_nxt      = pc;
        halt_det    = 1'b0;
        load_bubble = 1'b0;
        load_accept = 1'b0;

        case (state)
            ST_BOOT: state_nxt = ST_RUN;
            ST_RUN: begin
                // Only a halt word on the committed sequential path stops fetch.
                if (bus.inst_rdata == HALT_WORD && !redirect && !bus.flush && !bus.stall) begin
                    halt_det  = 1'b1;
                    state_nxt = ST_HALT;
                end
            end
            ST_HALT: if (redirect) state_nxt = ST_RUN;
            default: state_nxt = ST_BOOT;
        endcase

        // A redirect wins over stall, BOOT and HALT alike.
        case (bus.sel_pc)
            2'd1:    pc_nxt = jump_tgt;
            2'd2:    pc_nxt = br_tgt;
            2'd3:    pc_nxt = bus.jr_addr;
            default: if (state == ST_RUN && !bus.stall && !halt_det) pc_nxt = pc4;
        endcase

        if (bus.flush)                            load_bubble = 1'b1;
        else if (bus.stall)                       load_bubble = 1'b0;
        else if (state != ST_RUN || halt_det)     load_bubble = 1'b1;
        else                                      load_accept = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= ST_BOOT;
            pc    <= PC_RESET;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            if_id_inst  <= NOP_WORD;
            if_id_pc4   <= 32'd0;
            if_id_valid <= 1'b0;
        end else if (load_bubble) begin
            if_id_inst  <= NOP_WORD;
            if_id_pc4   <= 32'd0;
            if_id_valid <= 1'b0;
        end else if (load_accept) begin
            if_id_inst  <= bus.inst_rdata;
            if_id_pc4   <= pc4;
            if_id_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            fetch_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (load_accept && fetch_cnt != '1)  fetch_cnt  <= fetch_cnt + CNT_W'(1);
            if (load_bubble && bubble_cnt != '1) bubble_cnt <= bubble_cnt + CNT_W'(1);
        end
    end

endmodule
